// File: rtl/conv2d_engine_if.sv
// Bus bundle between conv2d_engine and its layer sequencer / memories.
// slave is the engine side; master is the sequencer and memory side.
interface conv2d_engine_if #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    localparam int IN_AW  = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1;
    localparam int W_AW   = (NUM_CH * K * K > 1) ? $clog2(NUM_CH * K * K) : 1;
    localparam int B_AW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int N_OUT  = NUM_CH * (IMG_H - K + 1) * (IMG_W - K + 1);
    localparam int OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic              start;
    logic              busy;
    logic              done;
    logic [IN_AW-1:0]  in_addr;
    logic [DATA_W-1:0] in_data;
    logic [W_AW-1:0]   w_addr;
    logic [DATA_W-1:0] w_data;
    logic [B_AW-1:0]   b_addr;
    logic [DATA_W-1:0] b_data;
    logic              out_we;
    logic [OUT_AW-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  start, in_data, w_data, b_data,
        output busy, done, in_addr, w_addr, b_addr, out_we, out_addr, out_data
    );

    modport master (
        output start, in_data, w_data, b_data,
        input  busy, done, in_addr, w_addr, b_addr, out_we, out_addr, out_data
    );
endinterface

// File: rtl/conv2d_engine.sv
// Stride-1, no-padding 2-D convolution of one plane with NUM_CH KxK kernels,
// followed by per-channel bias, arithmetic shift, optional ReLU and saturation.
module conv2d_engine #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int K       = 3,
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int SHIFT   = 0,
    parameter int RELU_EN = 1
) (
    input  logic           clk,
    input  logic           reset,
    conv2d_engine_if.slave bus
);
    localparam int OH     = IMG_H - K + 1;
    localparam int OW     = IMG_W - K + 1;
    localparam int IN_AW  = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1;
    localparam int W_AW   = (NUM_CH * K * K > 1) ? $clog2(NUM_CH * K * K) : 1;
    localparam int B_AW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OUT_AW = (NUM_CH * OH * OW > 1) ? $clog2(NUM_CH * OH * OW) : 1;
    localparam int MAXD_A = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int MAXD   = (MAXD_A > NUM_CH) ? MAXD_A : NUM_CH;
    localparam int CW     = $clog2(MAXD + 1);

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] ZERO    = CW'(0);
    localparam logic [CW-1:0] K_LAST  = CW'(K - 1);
    localparam logic [CW-1:0] OW_LAST = CW'(OW - 1);
    localparam logic [CW-1:0] OH_LAST = CW'(OH - 1);
    localparam logic [CW-1:0] CH_LAST = CW'(NUM_CH - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Shift, optional ReLU, then clamp into the signed DATA_W output range.
    function automatic logic [DATA_W-1:0] post_proc(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] v;
        logic [DATA_W-1:0]       res;
        v = acc >>> SHIFT;
        if ((RELU_EN != 0) && v[ACC_W-1]) begin
            v = {ACC_W{1'b0}};
        end else begin
            v = v;
        end
        if (v > SAT_MAX) begin
            res = SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            res = SAT_MIN[DATA_W-1:0];
        end else begin
            res = v[DATA_W-1:0];
        end
        return res;
    endfunction

    state_t                  state_q, state_d;
    logic [CW-1:0]           ch_q, ch_d, r_q, r_d, c_q, c_d, ky_q, ky_d, kx_q, kx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    busy_q, busy_d, done_q, done_d, out_we_q, out_we_d;
    logic [IN_AW-1:0]        in_addr_q, in_addr_d;
    logic [W_AW-1:0]         w_addr_q, w_addr_d;
    logic [B_AW-1:0]         b_addr_q, b_addr_d;
    logic [OUT_AW-1:0]       out_addr_q, out_addr_d;
    logic [DATA_W-1:0]       out_data_q, out_data_d;

    logic signed [2*DATA_W-1:0] pix_x_s, wgt_x_s, prod_s;
    logic signed [ACC_W-1:0]    prod_ext_s, bias_ext_s;

    assign pix_x_s    = {{DATA_W{bus.in_data[DATA_W-1]}}, bus.in_data};
    assign wgt_x_s    = {{DATA_W{bus.w_data[DATA_W-1]}}, bus.w_data};
    assign prod_s     = pix_x_s * wgt_x_s;
    assign prod_ext_s = {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
    assign bias_ext_s = {{(ACC_W-DATA_W){bus.b_data[DATA_W-1]}}, bus.b_data};

    // Sequencing, accumulation, and next values of every registered output.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        r_d     = r_q;
        c_d     = c_q;
        ky_d    = ky_q;
        kx_d    = kx_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_MAC;
                    ch_d = ZERO; r_d = ZERO; c_d = ZERO; ky_d = ZERO; kx_d = ZERO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MAC: begin
                // Data arriving on the first tap belongs to the previous pixel's WRITE cycle.
                if ((ky_q == ZERO) && (kx_q == ZERO)) begin
                    acc_d = {ACC_W{1'b0}};
                end else begin
                    acc_d = acc_q + prod_ext_s;
                end
                if (kx_q != K_LAST) begin
                    kx_d = kx_q + ONE;
                end else if (ky_q != K_LAST) begin
                    kx_d = ZERO;
                    ky_d = ky_q + ONE;
                end else begin
                    kx_d = ZERO;
                    ky_d = ZERO;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                acc_d   = acc_q + prod_ext_s + bias_ext_s;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_MAC;
                if (c_q != OW_LAST) begin
                    c_d = c_q + ONE;
                end else if (r_q != OH_LAST) begin
                    c_d = ZERO;
                    r_d = r_q + ONE;
                end else if (ch_q != CH_LAST) begin
                    c_d = ZERO;
                    r_d = ZERO;
                    ch_d = ch_q + ONE;
                end else begin
                    c_d = ZERO;
                    r_d = ZERO;
                    ch_d = ZERO;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d == S_MAC) || (state_d == S_DRAIN) || (state_d == S_WRITE);
        done_d   = (state_d == S_DONE);
        out_we_d = (state_d == S_WRITE);
        b_addr_d = B_AW'(ch_d);
        if (state_d == S_MAC) begin
            in_addr_d = IN_AW'((int'(r_d) + int'(ky_d)) * IMG_W + int'(c_d) + int'(kx_d));
            w_addr_d  = W_AW'(int'(ch_d) * K * K + int'(ky_d) * K + int'(kx_d));
        end else begin
            in_addr_d = {IN_AW{1'b0}};
            w_addr_d  = {W_AW{1'b0}};
        end
        if (state_d == S_WRITE) begin
            out_addr_d = OUT_AW'(int'(ch_d) * OH * OW + int'(r_d) * OW + int'(c_d));
            out_data_d = post_proc(acc_d);
        end else begin
            out_addr_d = {OUT_AW{1'b0}};
            out_data_d = {DATA_W{1'b0}};
        end
    end

    // State, counters, accumulator and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ch_q       <= ZERO;
            r_q        <= ZERO;
            c_q        <= ZERO;
            ky_q       <= ZERO;
            kx_q       <= ZERO;
            acc_q      <= {ACC_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_we_q   <= 1'b0;
            in_addr_q  <= {IN_AW{1'b0}};
            w_addr_q   <= {W_AW{1'b0}};
            b_addr_q   <= {B_AW{1'b0}};
            out_addr_q <= {OUT_AW{1'b0}};
            out_data_q <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            r_q        <= r_d;
            c_q        <= c_d;
            ky_q       <= ky_d;
            kx_q       <= kx_d;
            acc_q      <= acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            out_we_q   <= out_we_d;
            in_addr_q  <= in_addr_d;
            w_addr_q   <= w_addr_d;
            b_addr_q   <= b_addr_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.out_we   = out_we_q;
    assign bus.in_addr  = in_addr_q;
    assign bus.w_addr   = w_addr_q;
    assign bus.b_addr   = b_addr_q;
    assign bus.out_addr = out_addr_q;
    assign bus.out_data = out_data_q;
endmodule

// File: tb/tb_conv2d_engine.sv
// Bench for conv2d_engine: two configurations (4x4/K3/2ch/shift1/no-ReLU and
// 3x3/K1/1ch/ReLU) driven from a vector table, hand sequences and random planes.
module tb_conv2d_engine;
    localparam int A_NOUT = 8;
    localparam int A_LAT  = 8 * 11 + 1;
    localparam int B_NOUT = 9;
    localparam int B_LAT  = 9 * 3 + 1;

    logic clk = 1'b0;
    logic reset;

    conv2d_engine_if #(.IMG_W(4), .IMG_H(4), .K(3), .NUM_CH(2), .DATA_W(8)) ifa ();
    conv2d_engine_if #(.IMG_W(3), .IMG_H(3), .K(1), .NUM_CH(1), .DATA_W(8)) ifb ();

    conv2d_engine #(.IMG_W(4), .IMG_H(4), .K(3), .NUM_CH(2), .DATA_W(8), .ACC_W(24),
                    .SHIFT(1), .RELU_EN(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    conv2d_engine #(.IMG_W(3), .IMG_H(3), .K(1), .NUM_CH(1), .DATA_W(8), .ACC_W(24),
                    .SHIFT(0), .RELU_EN(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    int img [0:15];
    int wt  [0:31];
    int bs  [0:1];
    int got_a [0:7];
    int got_b [0:8];
    int wr_a, wr_b, done_a, done_b;
    int errors = 0;
    int checks = 0;

    typedef struct {
        bit sel;
        int p;
        int w;
        int b0;
        int b1;
        int e0;
        int e1;
    } vec_t;
    vec_t tbl [12];

    always #5 clk = ~clk;

    // Memories with one-cycle read latency, shared by both engines.
    always @(posedge clk) begin
        ifa.in_data <= 8'(img[ifa.in_addr]);
        ifa.w_data  <= 8'(wt[ifa.w_addr]);
        ifa.b_data  <= 8'(bs[ifa.b_addr]);
        ifb.in_data <= 8'(img[ifb.in_addr]);
        ifb.w_data  <= 8'(wt[ifb.w_addr]);
        ifb.b_data  <= 8'(bs[ifb.b_addr]);
    end

    // Output RAM capture and done-pulse counting.
    always @(negedge clk) begin
        if (ifa.out_we === 1'b1) begin
            got_a[ifa.out_addr] = int'($signed(ifa.out_data));
            wr_a++;
        end
        if (ifb.out_we === 1'b1) begin
            if (ifb.out_addr < 4'd9) got_b[ifb.out_addr] = int'($signed(ifb.out_data));
            wr_b++;
        end
        if (ifa.done === 1'b1) done_a++;
        if (ifb.done === 1'b1) done_b++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: direct sum over the kernel window, then bias/shift/ReLU/clamp.
    function automatic int ref_px(input int iw, input int k, input int sh, input int relu,
                                  input int ch, input int r, input int c);
        int acc;
        acc = bs[ch];
        for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++)
                acc += img[(r + ky) * iw + c + kx] * wt[ch * k * k + ky * k + kx];
        acc = acc >>> sh;
        if (relu != 0 && acc < 0) acc = 0;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        return acc;
    endfunction

    function automatic logic cur_done(input bit sel);
        return sel ? ifb.done : ifa.done;
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? ifb.busy : ifa.busy;
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) ifb.start = v;
        else     ifa.start = v;
    endtask

    task automatic fill_uniform(input int p, input int w, input int b0, input int b1);
        for (int i = 0; i < 16; i++) img[i] = p;
        for (int i = 0; i < 32; i++) wt[i] = w;
        bs[0] = b0;
        bs[1] = b1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(255, 0)) - 128;
        for (int i = 0; i < 32; i++) wt[i] = int'($urandom_range(255, 0)) - 128;
        for (int i = 0; i < 2; i++)  bs[i] = int'($urandom_range(255, 0)) - 128;
    endtask

    task automatic clear_capture();
        for (int i = 0; i < 8; i++) got_a[i] = 999;
        for (int i = 0; i < 9; i++) got_b[i] = 999;
        wr_a = 0; wr_b = 0; done_a = 0; done_b = 0;
    endtask

    task automatic wait_done(input bit sel, input string nm);
        int n = 0;
        while (cur_done(sel) !== 1'b1 && n < 500) begin
            @(posedge clk); n++; @(negedge clk);
        end
        chk({nm, " done seen"}, int'(cur_done(sel) === 1'b1), 1);
    endtask

    // One full run; the edge that samples start counts as edge 1.
    task automatic run(input bit sel, input string nm, input bit mid_start);
        int lat;
        clear_capture();
        @(negedge clk); set_start(sel, 1'b1);
        @(posedge clk); lat = 1;
        @(negedge clk); set_start(sel, 1'b0);
        chk({nm, " busy"}, int'(cur_busy(sel)), 1);
        while (cur_done(sel) !== 1'b1 && lat < 400) begin
            set_start(sel, mid_start && lat == 20);
            @(posedge clk); lat++; @(negedge clk);
        end
        set_start(sel, 1'b0);
        chk({nm, " done latency"}, lat, sel ? B_LAT : A_LAT);
        chk({nm, " busy at done"}, int'(cur_busy(sel)), 0);
        repeat (3) @(negedge clk);
        chk({nm, " writes"}, sel ? wr_b : wr_a, sel ? B_NOUT : A_NOUT);
        chk({nm, " done pulses"}, sel ? done_b : done_a, 1);
    endtask

    task automatic check_model(input bit sel, input string nm);
        if (!sel) begin
            for (int ch = 0; ch < 2; ch++)
                for (int r = 0; r < 2; r++)
                    for (int c = 0; c < 2; c++)
                        chk($sformatf("%s out[%0d]", nm, ch * 4 + r * 2 + c),
                            got_a[ch * 4 + r * 2 + c], ref_px(4, 3, 1, 0, ch, r, c));
        end else begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    chk($sformatf("%s out[%0d]", nm, r * 3 + c),
                        got_b[r * 3 + c], ref_px(3, 1, 0, 1, 0, r, c));
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0,    1,    1,   0,    0,    4,    4};
        tbl[1]  = '{1'b0,  127,  127,   0,    0,  127,  127};
        tbl[2]  = '{1'b0,  127, -128,   0,    0, -128, -128};
        tbl[3]  = '{1'b0,    2,    3,   5,   -3,   29,   25};
        tbl[4]  = '{1'b0,   -1,    1,   0, -128,   -5,  -69};
        tbl[5]  = '{1'b0,   14,    2,   7,    0,  127,  126};
        tbl[6]  = '{1'b1,    1,    1,   0,    0,    1,    0};
        tbl[7]  = '{1'b1,    3,   -2,   1,    0,    0,    0};
        tbl[8]  = '{1'b1,   10,   10, -90,    0,   10,    0};
        tbl[9]  = '{1'b1,  100,    2,   0,    0,  127,    0};
        tbl[10] = '{1'b1,   -1, -128,   0,    0,  127,    0};
        tbl[11] = '{1'b1,   -5,   -5,   3,    0,   28,    0};

        reset = 1'b1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        fill_uniform(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst busy",     int'(ifa.busy), 0);
        chk("rst done",     int'(ifa.done), 0);
        chk("rst out_we",   int'(ifa.out_we), 0);
        chk("rst in_addr",  int'(ifa.in_addr), 0);
        chk("rst w_addr",   int'(ifa.w_addr), 0);
        chk("rst b_addr",   int'(ifa.b_addr), 0);
        chk("rst out_addr", int'(ifa.out_addr), 0);
        chk("rst out_data", int'(ifa.out_data), 0);
        chk("rst b busy",   int'(ifb.busy), 0);
        chk("rst b out_we", int'(ifb.out_we), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            fill_uniform(tbl[i].p, tbl[i].w, tbl[i].b0, tbl[i].b1);
            run(tbl[i].sel, $sformatf("tbl%0d", i), 1'b0);
            for (int a = 0; a < (tbl[i].sel ? B_NOUT : A_NOUT); a++)
                chk($sformatf("tbl%0d out[%0d]", i, a),
                    tbl[i].sel ? got_b[a] : got_a[a],
                    (tbl[i].sel || a < 4) ? tbl[i].e0 : tbl[i].e1);
        end

        // Ramp image with per-channel bias {5,-3}.
        fill_random();
        for (int i = 0; i < 16; i++) img[i] = i;
        bs[0] = 5;
        bs[1] = -3;
        run(1'b0, "ramp", 1'b0);
        check_model(1'b0, "ramp");

        for (int t = 0; t < 3; t++) begin
            fill_random();
            run(1'b0, $sformatf("randA%0d", t), 1'b0);
            check_model(1'b0, $sformatf("randA%0d", t));
        end
        for (int t = 0; t < 2; t++) begin
            fill_random();
            run(1'b1, $sformatf("randB%0d", t), 1'b0);
            check_model(1'b1, $sformatf("randB%0d", t));
        end

        // Reset in the middle of pixel 2's MAC phase, then a clean rerun.
        fill_random();
        @(negedge clk); ifa.start = 1'b1;
        @(posedge clk);
        @(negedge clk); ifa.start = 1'b0;
        repeat (26) @(posedge clk);
        #2;
        chk("abort busy before", int'(ifa.busy), 1);
        reset = 1'b1;
        #1;
        chk("abort busy",    int'(ifa.busy), 0);
        chk("abort out_we",  int'(ifa.out_we), 0);
        chk("abort in_addr", int'(ifa.in_addr), 0);
        chk("abort w_addr",  int'(ifa.w_addr), 0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        run(1'b0, "after abort", 1'b0);
        check_model(1'b0, "after abort");

        // Start pulsed while busy must not restart or double the done pulse.
        fill_random();
        run(1'b0, "mid start", 1'b1);
        check_model(1'b0, "mid start");

        // Start held high: one IDLE cycle after DONE, then the next run.
        clear_capture();
        @(negedge clk); ifa.start = 1'b1;
        wait_done(1'b0, "held run1");
        clear_capture();
        @(posedge clk); @(negedge clk);
        chk("held idle busy", int'(ifa.busy), 0);
        chk("held idle done", int'(ifa.done), 0);
        @(posedge clk); @(negedge clk);
        chk("held restart busy", int'(ifa.busy), 1);
        ifa.start = 1'b0;
        wait_done(1'b0, "held run2");
        repeat (2) @(negedge clk);
        chk("held run2 writes", wr_a, A_NOUT);
        check_model(1'b0, "held run2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end
endmodule
